// File: rtl/mem_access_controller.sv
//------------------------------------------------------------------------------
// mem_access_controller
//   Memory-stage load/store sequencer: alignment check, lane steering, load
//   extension and a bounded-wait data-memory handshake.
//   Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_access_controller #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_write,
    input  logic        wb_load,
    input  logic [1:0]  mem_store_type,
    input  logic [2:0]  mem_load_type,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_store;
    logic [1:0]       r_st_type;
    logic [2:0]       r_ld_type;
    logic [31:0]      r_addr;
    logic [31:0]      r_sdata;
    logic [31:0]      r_load_data;
    logic             r_misal;
    logic             r_berr;

    logic        w_st_ok;
    logic        w_ld_ok;
    logic        w_valid;
    logic        w_misal;
    logic        w_stall;
    logic        w_req;
    logic        w_done;
    logic        w_timeout;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;

    // A store wins whenever it is itself well-formed, regardless of wb_load.
    assign w_st_ok = mem_write & (mem_store_type != 2'b11);
    assign w_ld_ok = wb_load & (mem_load_type != 3'b111);
    assign w_valid = start & (w_st_ok | w_ld_ok);

    always_comb begin
        w_misal = 1'b0;
        if (w_st_ok) begin
            if (mem_store_type == ST_SH)      w_misal = addr[0];
            else if (mem_store_type == ST_SW) w_misal = (addr[1:0] != 2'b00);
        end else begin
            if (mem_load_type == LD_LH || mem_load_type == LD_LHU) w_misal = addr[0];
            else if (mem_load_type == LD_LW) w_misal = (addr[1:0] != 2'b00);
        end
    end

    assign w_timeout = (r_cnt == CNT_LAST);

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_req   = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_stall = 1'b1;
                    w_next  = w_misal ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_stall = 1'b1;
                w_req   = 1'b1;
                if (dmem_ack || w_timeout) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_ld_type)
            LD_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
            LD_LH:   w_ext = {{16{w_half[15]}}, w_half};
            LD_LBU:  w_ext = {24'h0, w_byte};
            LD_LHU:  w_ext = {16'h0, w_half};
            default: w_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_is_store  <= 1'b0;
            r_st_type   <= 2'b11;
            r_ld_type   <= 3'b111;
            r_addr      <= '0;
            r_sdata     <= '0;
            r_load_data <= '0;
            r_misal     <= 1'b0;
            r_berr      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_cnt       <= '0;
                        r_is_store  <= w_st_ok;
                        r_st_type   <= mem_store_type;
                        r_ld_type   <= mem_load_type;
                        r_addr      <= addr;
                        r_sdata     <= store_data;
                        r_load_data <= '0;
                        r_misal     <= w_misal;
                        r_berr      <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    // Ack takes precedence over an expiring counter.
                    if (dmem_ack) begin
                        r_load_data <= r_is_store ? 32'h0 : w_ext;
                    end else if (w_timeout) begin
                        r_berr      <= 1'b1;
                        r_load_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_wdata = 32'h0;
        w_be    = 4'b1111;
        if (r_is_store) begin
            case (r_st_type)
                ST_SB: begin
                    w_wdata = {4{r_sdata[7:0]}};
                    w_be    = 4'b0001 << r_addr[1:0];
                end
                ST_SH: begin
                    w_wdata = {2{r_sdata[15:0]}};
                    w_be    = 4'b0011 << {r_addr[1], 1'b0};
                end
                default: w_wdata = r_sdata;
            endcase
        end
    end

    assign stall      = w_stall & ~rst;
    assign done       = w_done;
    assign load_data  = w_done ? r_load_data : 32'h0;
    assign misaligned = w_done & r_misal;
    assign bus_error  = w_done & r_berr;
    assign dmem_req   = w_req;
    assign dmem_we    = w_req & r_is_store;
    assign dmem_addr  = {r_addr[31:2], 2'b00};
    assign dmem_wdata = w_wdata;
    assign dmem_be    = w_req ? w_be : 4'b0000;

endmodule

`default_nettype wire
